// File: rtl/gate_vec_sweeper_if.sv
// Stimulus/result bundle between the sweeper and whatever controls it and hosts the gate array.
interface gate_vec_sweeper_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] gate_in;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [15:0]      vec_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [WIDTH-1:0] fail_exp;
  logic [WIDTH-1:0] fail_got;

  modport slave (
    input  start, op, gate_in,
    output a_out, b_out, busy, done, pass, err_count, vec_count,
           fail_valid, fail_a, fail_b, fail_exp, fail_got
  );

  modport master (
    output start, op, gate_in,
    input  a_out, b_out, busy, done, pass, err_count, vec_count,
           fail_valid, fail_a, fail_b, fail_exp, fail_got
  );
endinterface

// File: rtl/gate_vec_sweeper.sv
// Walks a/b operand patterns through a two-input gate array, checks each result
// against a selectable reference function and records the first mismatch.
module gate_vec_sweeper #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  gate_vec_sweeper_if.slave  bus
);
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]      err_q, err_d, vec_q, vec_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fe_q, fe_d, fg_q, fg_d;
  logic [WIDTH-1:0] exp_c, next_a_c;
  logic             mismatch_c;

  // Reference function of the latched op applied to the operands on the bus
  always_comb begin
    exp_c = a_q;
    case (op_q)
      3'd0:    exp_c = a_q & b_q;
      3'd1:    exp_c = ~(a_q & b_q);
      3'd2:    exp_c = a_q | b_q;
      3'd3:    exp_c = ~(a_q | b_q);
      3'd4:    exp_c = a_q ^ b_q;
      3'd5:    exp_c = ~(a_q ^ b_q);
      3'd6:    exp_c = a_q;
      default: exp_c = ~a_q;
    endcase
  end

  // X/Z on the array output counts as a mismatch
  assign mismatch_c = (bus.gate_in !== exp_c);
  assign next_a_c   = (a_q << 1) | WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      vec_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fe_q    <= '0;
      fg_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fe_q    <= fe_d;
      fg_q    <= fg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    vec_d   = vec_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fe_d    = fe_q;
    fg_d    = fg_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = WIDTH'(1);
          b_d     = ALL_ONES;
          cnt_d   = CNT_LOAD;
          pass_d  = 1'b0;
          err_d   = '0;
          vec_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          fe_d    = '0;
          fg_d    = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        vec_d = vec_q + 16'd1;
        if (mismatch_c) begin
          err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
            fe_d = exp_c;
            fg_d = bus.gate_in;
          end
        end
        cnt_d = CNT_LOAD;
        if ((b_q >> 1) != '0) begin
          b_d     = b_q >> 1;
          state_d = APPLY;
        end else if (next_a_c != ALL_ONES) begin
          a_d     = next_a_c;
          b_d     = ALL_ONES;
          state_d = APPLY;
        end else begin
          pass_d  = (err_d == 16'd0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.vec_count  = vec_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_a     = fa_q;
  assign bus.fail_b     = fb_q;
  assign bus.fail_exp   = fe_q;
  assign bus.fail_got   = fg_q;
endmodule

// File: tb/tb_gate_vec_sweeper.sv
// Directed bench: one sweeper with a configurable NAND-style array model, plus a
// SETTLE=3 sweeper driving a two-clock-delayed NAND array.
module tb_gate_vec_sweeper;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] mode;
  logic [15:0] d1, d2, e1, e2;
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  gate_vec_sweeper_if #(.WIDTH(16)) intf ();
  gate_vec_sweeper_if #(.WIDTH(16)) intf3 ();

  gate_vec_sweeper #(.WIDTH(16), .SETTLE(1)) u_dut  (.clk(clk), .reset_n(reset_n), .bus(intf));
  gate_vec_sweeper #(.WIDTH(16), .SETTLE(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(intf3));

  // Array models: 0 NAND, 1 NAND with bit0 stuck-at-1, 2 NAND delayed two clocks, 3 XOR
  always @(posedge clk) begin
    d1 <= ~(intf.a_out & intf.b_out);
    d2 <= d1;
    e1 <= ~(intf3.a_out & intf3.b_out);
    e2 <= e1;
  end
  assign intf.gate_in = (mode == 2'd0) ? ~(intf.a_out & intf.b_out) :
                        (mode == 2'd1) ? (~(intf.a_out & intf.b_out) | 16'h0001) :
                        (mode == 2'd2) ? d2 : (intf.a_out ^ intf.b_out);
  assign intf3.gate_in = e2;

  // Pulses start with opv, then counts edges until done (optionally a stray start at extra_at)
  task automatic run_sweep(input logic [2:0] opv, input int extra_at, output int cyc);
    @(negedge clk);
    intf.op = opv;
    intf.start = 1'b1;
    @(posedge clk);
    #1 intf.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == extra_at) begin intf.start = 1'b1; intf.op = 3'd0; end
      else intf.start = 1'b0;
    end while (intf.done !== 1'b1 && cyc < 3000);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_vec++; if ({intf.a_out, intf.b_out, intf.busy, intf.done, intf.pass, intf.err_count, intf.vec_count, intf.fail_valid} !== 36'h0) begin n_miss++; $display("FAIL reset_outputs got %h want 0", {intf.a_out, intf.b_out, intf.busy, intf.done, intf.pass}); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({intf.busy, intf.done, intf.a_out} !== 18'h0) begin n_miss++; $display("FAIL idle_after_reset got busy=%b done=%b a=%h want 0", intf.busy, intf.done, intf.a_out); end
  endtask

  task automatic test_nand_clean();
    int cyc;
    mode = 2'd0;
    run_sweep(3'd1, 0, cyc);
    n_vec++; if (cyc !== 480) begin n_miss++; $display("FAIL nand_latency got %0d want 480", cyc); end
    n_vec++; if (intf.err_count !== 16'd0) begin n_miss++; $display("FAIL nand_err got %0d want 0", intf.err_count); end
    n_vec++; if (intf.vec_count !== 16'd240) begin n_miss++; $display("FAIL nand_vec got %0d want 240", intf.vec_count); end
    n_vec++; if ({intf.pass, intf.fail_valid, intf.busy} !== 3'b100) begin n_miss++; $display("FAIL nand_flags got pass/fv/busy=%b want 100", {intf.pass, intf.fail_valid, intf.busy}); end
    n_vec++; if ({intf.a_out, intf.b_out} !== 32'h7fff_0001) begin n_miss++; $display("FAIL nand_last_vec got %h want 7fff0001", {intf.a_out, intf.b_out}); end
  endtask

  task automatic test_stuck_bit();
    int cyc;
    mode = 2'd1;
    run_sweep(3'd1, 0, cyc);
    n_vec++; if (intf.err_count !== 16'd240) begin n_miss++; $display("FAIL stuck_err got %0d want 240", intf.err_count); end
    n_vec++; if ({intf.pass, intf.fail_valid} !== 2'b01) begin n_miss++; $display("FAIL stuck_flags got pass/fv=%b want 01", {intf.pass, intf.fail_valid}); end
    n_vec++; if ({intf.fail_a, intf.fail_b, intf.fail_exp, intf.fail_got} !== 64'h0001_ffff_fffe_ffff) begin n_miss++; $display("FAIL stuck_capture got %h want 0001fffffffeffff", {intf.fail_a, intf.fail_b, intf.fail_exp, intf.fail_got}); end
  endtask

  task automatic test_op_and();
    int cyc;
    mode = 2'd0;
    run_sweep(3'd0, 0, cyc);
    n_vec++; if (intf.err_count !== 16'd240) begin n_miss++; $display("FAIL and_err got %0d want 240", intf.err_count); end
    n_vec++; if ({intf.fail_exp, intf.fail_got} !== 32'h0001_fffe) begin n_miss++; $display("FAIL and_capture got %h want 0001fffe", {intf.fail_exp, intf.fail_got}); end
    n_vec++; if (intf.pass !== 1'b0) begin n_miss++; $display("FAIL and_pass got %b want 0", intf.pass); end
  endtask

  task automatic test_op_xor();
    int cyc;
    mode = 2'd3;
    run_sweep(3'd4, 0, cyc);
    n_vec++; if ({intf.pass, intf.err_count, intf.vec_count} !== {1'b1, 16'd0, 16'd240}) begin n_miss++; $display("FAIL xor_result got pass=%b err=%0d vec=%0d want 1/0/240", intf.pass, intf.err_count, intf.vec_count); end
  endtask

  task automatic test_sequence_and_reset();
    int cyc;
    mode = 2'd0;
    @(negedge clk);
    intf.op = 3'd1;
    intf.start = 1'b1;
    @(posedge clk);
    #1 intf.start = 1'b0;
    n_vec++; if ({intf.busy, intf.done, intf.a_out, intf.b_out} !== {2'b10, 32'h0001_ffff}) begin n_miss++; $display("FAIL first_vec got %h want 20001ffff", {intf.busy, intf.done, intf.a_out, intf.b_out}); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({intf.a_out, intf.b_out, intf.vec_count} !== 48'h0001_7fff_0001) begin n_miss++; $display("FAIL second_vec got %h want 00017fff0001", {intf.a_out, intf.b_out, intf.vec_count}); end
    repeat (30) @(posedge clk);
    #1;
    n_vec++; if ({intf.a_out, intf.b_out, intf.vec_count} !== 48'h0003_ffff_0010) begin n_miss++; $display("FAIL a_step got %h want 0003ffff0010", {intf.a_out, intf.b_out, intf.vec_count}); end
    repeat (68) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++; if ({intf.a_out, intf.b_out, intf.busy, intf.done, intf.pass, intf.err_count, intf.vec_count, intf.fail_valid, intf.fail_a, intf.fail_b, intf.fail_exp, intf.fail_got} !== 100'h0) begin n_miss++; $display("FAIL midsweep_reset got a=%h b=%h busy=%b vec=%0d want 0", intf.a_out, intf.b_out, intf.busy, intf.vec_count); end
    @(negedge clk);
    reset_n = 1'b1;
    run_sweep(3'd1, 0, cyc);
    n_vec++; if ({cyc, intf.pass, intf.vec_count} !== {32'd480, 1'b1, 16'd240}) begin n_miss++; $display("FAIL after_reset_sweep got cyc=%0d pass=%b vec=%0d want 480/1/240", cyc, intf.pass, intf.vec_count); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = 2'd0;
    run_sweep(3'd1, 50, cyc);
    n_vec++; if ({cyc, intf.pass, intf.err_count} !== {32'd480, 1'b1, 16'd0}) begin n_miss++; $display("FAIL stray_start got cyc=%0d pass=%b err=%0d want 480/1/0", cyc, intf.pass, intf.err_count); end
    mode = 2'd1;
    run_sweep(3'd1, 0, cyc);
    mode = 2'd0;
    @(negedge clk);
    intf.op = 3'd1;
    intf.start = 1'b1;
    @(posedge clk);
    #1 intf.start = 1'b0;
    n_vec++; if ({intf.done, intf.pass, intf.err_count, intf.vec_count, intf.fail_valid, intf.fail_a} !== 51'h0) begin n_miss++; $display("FAIL restart_clear got done=%b err=%0d vec=%0d fv=%b want 0", intf.done, intf.err_count, intf.vec_count, intf.fail_valid); end
    cyc = 0;
    while (intf.done !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    n_vec++; if ({cyc, intf.pass, intf.vec_count} !== {32'd480, 1'b1, 16'd240}) begin n_miss++; $display("FAIL restart_sweep got cyc=%0d pass=%b vec=%0d want 480/1/240", cyc, intf.pass, intf.vec_count); end
  endtask

  task automatic test_settle();
    int cyc;
    @(negedge clk);
    intf3.op = 3'd1;
    intf3.start = 1'b1;
    @(posedge clk);
    #1 intf3.start = 1'b0;
    cyc = 0;
    while (intf3.done !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    n_vec++; if (cyc !== 960) begin n_miss++; $display("FAIL settle3_latency got %0d want 960", cyc); end
    n_vec++; if ({intf3.pass, intf3.err_count, intf3.vec_count} !== {1'b1, 16'd0, 16'd240}) begin n_miss++; $display("FAIL settle3_result got pass=%b err=%0d vec=%0d want 1/0/240", intf3.pass, intf3.err_count, intf3.vec_count); end
    mode = 2'd2;
    run_sweep(3'd1, 0, cyc);
    n_vec++; if (intf.err_count === 16'd0 || intf.pass !== 1'b0) begin n_miss++; $display("FAIL settle1_delayed got err=%0d pass=%b want err>0 pass=0", intf.err_count, intf.pass); end
  endtask

  initial begin
    intf.start = 1'b0;
    intf.op = 3'd0;
    intf3.start = 1'b0;
    intf3.op = 3'd0;
    mode = 2'd0;
    test_reset();
    test_nand_clean();
    test_stuck_bit();
    test_op_and();
    test_op_xor();
    test_sequence_and_reset();
    test_back_to_back();
    test_settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
